ref_row_scheduler: RTL and testbench
====================================

// Module: ref_row_scheduler
// PURPOSE
//  Sequences reference-window delivery to the SAD array. Fetches 8x32-pixel tiles
//  from the reference SRAM and streams them out one 32-pixel row per beat over a
//  valid/ready interface. A ping-pong tile buffer overlaps each fetch with streaming,
//  so rows leave back-to-back. One start pulse processes one vertical window of
//  NUM_TILES tiles.
// PARAMETERS
//  PIXEL     8   bits per pixel
//  COLS      32  pixels per row
//  ROWS      8   rows per tile
//  NUM_TILES 8   tiles per window (>=1)
//  ADDR_W    6   SRAM address width; one address holds one tile
// PORTS
//  clk          in  1                clock, rising edge
//  rst_n        in  1                reset, asynchronous, active-low
//  start        in  1                1-cycle pulse; begins a window; ignored while busy
//  base_addr    in  ADDR_W           tile address of tile 0; sampled with start
//  busy         out 1                high from cycle after start until done
//  done         out 1                1-cycle pulse after last row accepted
//  mem_rd_en    out 1                SRAM read strobe, registered
//  mem_rd_addr  out ADDR_W           SRAM read address, registered
//  mem_rd_data  in  ROWS*COLS*PIXEL  tile; pixel(c,r) at [(c*ROWS+r)*PIXEL +: PIXEL]; valid 1 cycle after rd_en
//  row_valid    out 1                row_data valid
//  row_ready    in  1                downstream accepts; beat = valid & ready
//  row_data     out COLS*PIXEL       row r of current tile; column 0 in MSBs
//  row_idx      out 3                row index within tile, 0..ROWS-1
//  tile_idx     out $clog2(NUM_TILES+1)  tile index within window
//  row_last     out 1                high on final row of final tile
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, both buffer full flags 0, buffers cleared, counters 0.
//  FSM: IDLE -start-> RUN -final beat-> DONE -> IDLE (DONE lasts exactly 1 cycle, done=1).
//  Fetch side (RUN): fetch_cnt 0..NUM_TILES. Issue mem_rd_en=1, mem_rd_addr=base+fetch_cnt
//   (mod 2^ADDR_W, wraps silently) when fetch_cnt<NUM_TILES, full[wr_sel]=0 and no read in
//   flight. Next cycle mem_rd_data is written to buf[wr_sel], full[wr_sel]<=1, wr_sel toggles.
//   Full flags are registered: a buffer freed on cycle t can be re-requested on t+1 at earliest.
//  Stream side: row_valid=full[rd_sel]; row_data=row row_cnt of buf[rd_sel]. On beat row_cnt++;
//   on beat with row_cnt=ROWS-1: row_cnt<=0, full[rd_sel]<=0, rd_sel toggles, tile_cnt++.
//  row_data/row_idx/tile_idx stable while row_valid & !row_ready (AXI-style hold).
//  Latency: start sampled at edge k -> mem_rd_en high after k -> data captured at k+2 ->
//   row_valid high after k+2. Ready held high: 8*NUM_TILES consecutive beats, no bubbles.
//  NUM_TILES=1: single fetch, 8 beats, row_last on beat 8. start during RUN/DONE: ignored.
//  Simultaneous beat-frees-buffer and capture-into-other-buffer: both take effect.
//  Reset mid-window: immediate return to IDLE; in-flight read data discarded; no done pulse.
// STRUCTURE
//  Package ref_pkg: PIXEL, COLS, ROWS, TILE_W=ROWS*COLS*PIXEL, ROW_W=COLS*PIXEL,
//   function pix_ofs(c,r) returning (c*ROWS+r)*PIXEL, FSM state enum {IDLE,RUN,DONE}.
//  Sub-module ref_tile_pingpong: two TILE_W registers, full flags, wr_sel/rd_sel, row mux
//   (row extraction: column c of row r from pix_ofs(c,r)). Top keeps FSM, counters, SRAM I/F.
// TESTING
//  T1 base=5, NUM_TILES=2, ready=1, tile n pixel(c,r)=n*64+r*8+c[2:0] -> addrs 5,6; 16 beats
//   back-to-back starting 2 edges after start; row_data matches; row_last on beat 16; done once.
//  T2 ready toggling 1/0 each cycle -> data held while stalled; no row lost/duplicated; <=2 fetches ahead.
//  T3 ready=0 for 40 cycles after first valid -> exactly 2 reads issued, then rd_en stays 0 until a buffer frees.
//  T4 base=63, ADDR_W=6, NUM_TILES=3 -> addresses 63,0,1.
//  T5 rst_n low at beat 5 of tile 1 -> all outputs 0 asynchronously; new start after release runs clean window.
//  T6 start pulsed again mid-window and NUM_TILES=1 -> second start ignored; 8 beats, single done pulse.

Source files
------------

// File: rtl/ref_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ref_pkg
// Description : Shared geometry constants, pixel-offset helper and FSM state
//               type for the reference-row scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ref_pkg;

    localparam int PIXEL  = 8;               // bits per pixel
    localparam int COLS   = 32;              // pixels per row
    localparam int ROWS   = 8;               // rows per tile
    localparam int TILE_W = ROWS * COLS * PIXEL;
    localparam int ROW_W  = COLS * PIXEL;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // SRAM tiles are stored column-major: pixel (c,r) sits at this bit offset.
    function automatic int pix_ofs(input int c, input int r);
        return (c * ROWS + r) * PIXEL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_tile_pingpong.sv
`default_nettype none
// ============================================================================
// Module      : ref_tile_pingpong
// Description : Two-entry tile buffer. One side is filled from SRAM while the
//               other is streamed out row by row.
// Ports       : wr_en/wr_data  - capture a tile into the write-side buffer
//               rd_free        - release the read-side buffer (last row taken)
//               row_sel        - row of the read-side tile to present
//               wr_full        - write-side buffer still occupied
//               row_valid      - read-side buffer holds a tile
//               row_data       - selected row, column 0 in the MSBs
// Revision    : 1.0 - initial release
// ============================================================================
module ref_tile_pingpong
    import ref_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [TILE_W-1:0] wr_data,
    input  logic              rd_free,
    input  logic [2:0]        row_sel,
    output logic              wr_full,
    output logic              row_valid,
    output logic [ROW_W-1:0]  row_data
);

    logic [TILE_W-1:0] tile_q [2];
    logic [TILE_W-1:0] tile_d [2];
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              wr_sel_q;
    logic              wr_sel_d;
    logic              rd_sel_q;
    logic              rd_sel_d;
    logic [TILE_W-1:0] cur_tile;

    // A capture always targets an empty buffer and a release always targets a
    // full one, so the two updates never touch the same entry.
    always_comb begin
        tile_d[0] = tile_q[0];
        tile_d[1] = tile_q[1];
        full_d    = full_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        if (wr_en) begin
            tile_d[wr_sel_q] = wr_data;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (rd_free) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_q[0] <= '0;
            tile_q[1] <= '0;
            full_q    <= 2'b00;
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            tile_q[0] <= tile_d[0];
            tile_q[1] <= tile_d[1];
            full_q    <= full_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    assign wr_full   = full_q[wr_sel_q];
    assign row_valid = full_q[rd_sel_q];
    assign cur_tile  = tile_q[rd_sel_q];

    // Gather one row out of the column-major tile.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < COLS; c++) begin
            row_data[(COLS-1-c)*PIXEL +: PIXEL] = cur_tile[pix_ofs(c, int'(row_sel)) +: PIXEL];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ref_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ref_row_scheduler
// Description : Fetches NUM_TILES consecutive tiles from the reference SRAM
//               and streams them one row per beat over valid/ready, using a
//               ping-pong buffer so fetches overlap streaming.
// Ports       : start/base_addr - launch one window at base_addr
//               busy/done       - window in progress / 1-cycle completion
//               mem_rd_*        - registered SRAM read port (1-cycle latency)
//               row_*           - row stream with indices and last marker
// Revision    : 1.0 - initial release
// ============================================================================
module ref_row_scheduler
    import ref_pkg::*;
#(
    parameter int NUM_TILES = 8,
    parameter int ADDR_W    = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                base_addr,
    output logic                             busy,
    output logic                             done,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_rd_addr,
    input  logic [TILE_W-1:0]                mem_rd_data,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [ROW_W-1:0]                 row_data,
    output logic [2:0]                       row_idx,
    output logic [$clog2(NUM_TILES+1)-1:0]   tile_idx,
    output logic                             row_last
);

    localparam int               CNT_W     = $clog2(NUM_TILES + 1);
    localparam logic [CNT_W-1:0] TILES_C   = CNT_W'(NUM_TILES);
    localparam logic [CNT_W-1:0] LAST_TILE = CNT_W'(NUM_TILES - 1);
    localparam logic [2:0]       LAST_ROW  = 3'(ROWS - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [2:0]         row_cnt_q, row_cnt_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               cap_q, cap_d;

    logic               buf_wr_full;
    logic               buf_valid;
    logic               beat;
    logic               last_row;
    logic               tile_free;

    assign beat      = (state_q == RUN) && buf_valid && row_ready;
    assign last_row  = (row_cnt_q == LAST_ROW);
    assign tile_free = beat && last_row;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        fetch_cnt_d = fetch_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        row_cnt_d   = row_cnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        // SRAM returns data one cycle after the strobe; this marks the capture cycle.
        cap_d       = rd_en_q;
        case (state_q)
            IDLE: begin
                // First read goes out with start itself so data lands two edges later.
                if (start) begin
                    state_d     = RUN;
                    base_d      = base_addr;
                    fetch_cnt_d = CNT_W'(1);
                    tile_cnt_d  = '0;
                    row_cnt_d   = '0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = base_addr;
                end
            end
            RUN: begin
                if ((fetch_cnt_q < TILES_C) && !buf_wr_full && !rd_en_q && !cap_q) begin
                    rd_en_d     = 1'b1;
                    rd_addr_d   = base_q + ADDR_W'(fetch_cnt_q);
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                end
                if (beat) begin
                    if (last_row) begin
                        row_cnt_d  = '0;
                        tile_cnt_d = tile_cnt_q + CNT_W'(1);
                        if (tile_cnt_q == LAST_TILE) begin
                            state_d = DONE;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + 3'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= '0;
            fetch_cnt_q <= '0;
            tile_cnt_q  <= '0;
            row_cnt_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            fetch_cnt_q <= fetch_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            row_cnt_q   <= row_cnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cap_q       <= cap_d;
        end
    end

    ref_tile_pingpong u_pingpong (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (cap_q),
        .wr_data   (mem_rd_data),
        .rd_free   (tile_free),
        .row_sel   (row_cnt_q),
        .wr_full   (buf_wr_full),
        .row_valid (buf_valid),
        .row_data  (row_data)
    );

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_addr_q;
    assign row_valid   = buf_valid;
    assign row_idx     = row_cnt_q;
    assign tile_idx    = tile_cnt_q;
    assign row_last    = buf_valid && last_row && (tile_cnt_q == LAST_TILE);

endmodule
`default_nettype wire

// File: tb/tb_ref_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ref_row_scheduler
// Description : Self-checking bench for ref_row_scheduler. Three instances
//               (NUM_TILES = 1, 2, 3) share clock, reset and ready; one is
//               active at a time. Expected rows and read addresses are queued
//               when a window starts and popped as the DUT produces them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_row_scheduler;

    localparam int M_ALWAYS = 0;
    localparam int M_TOGGLE = 1;
    localparam int M_RANDOM = 2;

    typedef struct {
        logic [255:0] data;
        logic [2:0]   r;
        logic [3:0]   t;
        logic         last;
    } beat_t;

    typedef struct {
        int         dut;
        logic [5:0] base;
        int         mode;
        bit         restart;
        int         exp_beats;
        int         exp_fetches;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] start_v;
    logic [5:0] base_addr;
    logic       row_ready;
    int         cur;
    int         cyc = 0;

    logic         busy_v  [3];
    logic         done_v  [3];
    logic         rden_v  [3];
    logic [5:0]   addr_v  [3];
    logic         rv_v    [3];
    logic         rl_v    [3];
    logic [2:0]   ridx_v  [3];
    logic [3:0]   tidx_v  [3];
    logic [255:0] rdata_v [3];

    logic         busy, done, rd_en, row_valid, row_last;
    logic [5:0]   rd_addr;
    logic [2:0]   row_idx;
    logic [3:0]   tile_idx;
    logic [255:0] row_data;

    int checks   = 0;
    int failures = 0;

    beat_t      exp_beat_q [$];
    logic [5:0] exp_addr_q [$];
    int beats_seen, fetches_seen, tiles_done, dones, first_cyc, last_cyc;

    logic         prev_stall = 1'b0;
    logic [255:0] hold_data;
    logic [2:0]   hold_idx;
    logic [3:0]   hold_tidx;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference pixel: tile at SRAM address a, pixel (c,r) = a*64 + r*8 + c[2:0].
    function automatic logic [7:0] pix(input logic [5:0] a, input int r, input int c);
        return 8'(int'(a) * 64 + r * 8 + (c % 8));
    endfunction

    function automatic logic [2047:0] mem_tile(input logic [5:0] a);
        logic [2047:0] t;
        t = '0;
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 8; r++)
                t[(c*8+r)*8 +: 8] = pix(a, r, c);
        return t;
    endfunction

    function automatic logic [255:0] exp_row(input logic [5:0] a, input int r);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < 32; c++) v[(31-c)*8 +: 8] = pix(a, r, c);
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NT = g + 1;
        localparam int TW = $clog2(NT + 1);
        logic          b, d, re, rv, rl;
        logic [5:0]    ra;
        logic [255:0]  rdat;
        logic [2:0]    ri;
        logic [TW-1:0] ti;
        logic [2047:0] mdat;

        ref_row_scheduler #(.NUM_TILES(NT), .ADDR_W(6)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start       (start_v[g]),
            .base_addr   (base_addr),
            .busy        (b),
            .done        (d),
            .mem_rd_en   (re),
            .mem_rd_addr (ra),
            .mem_rd_data (mdat),
            .row_valid   (rv),
            .row_ready   (row_ready),
            .row_data    (rdat),
            .row_idx     (ri),
            .tile_idx    (ti),
            .row_last    (rl)
        );

        // SRAM model: one-cycle read latency.
        always @(posedge clk) if (re) mdat <= mem_tile(ra);

        assign busy_v[g]  = b;
        assign done_v[g]  = d;
        assign rden_v[g]  = re;
        assign addr_v[g]  = ra;
        assign rv_v[g]    = rv;
        assign rl_v[g]    = rl;
        assign ridx_v[g]  = ri;
        assign tidx_v[g]  = 4'(ti);
        assign rdata_v[g] = rdat;
    end

    always_comb begin
        busy      = busy_v[cur];
        done      = done_v[cur];
        rd_en     = rden_v[cur];
        rd_addr   = addr_v[cur];
        row_valid = rv_v[cur];
        row_last  = rl_v[cur];
        row_idx   = ridx_v[cur];
        tile_idx  = tidx_v[cur];
        row_data  = rdata_v[cur];
    end

    task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", 300'({row_valid, row_idx, tile_idx, row_data}),
                            300'({1'b1, hold_idx, hold_tidx, hold_data}));
            if (row_valid && row_ready) begin
                if (exp_beat_q.size() == 0) begin
                    chk_int("extra_beat", 1, 0);
                end else begin
                    e = exp_beat_q.pop_front();
                    chk("beat", 300'({row_idx, tile_idx, row_last, row_data}),
                                300'({e.r, e.t, e.last, e.data}));
                end
                if (beats_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats_seen++;
                if (row_idx == 3'd7) tiles_done++;
            end
            prev_stall = row_valid && !row_ready;
            hold_data  = row_data;
            hold_idx   = row_idx;
            hold_tidx  = tile_idx;
            if (rd_en) begin
                if (exp_addr_q.size() == 0) begin
                    chk_int("extra_read", 1, 0);
                end else begin
                    chk("rd_addr", 300'(rd_addr), 300'(exp_addr_q.pop_front()));
                end
                fetches_seen++;
                chk_int("fetch_ahead_le2", int'((fetches_seen - tiles_done) <= 2), 1);
            end
            if (done) dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prepare(input int d, input logic [5:0] base);
        cur          = d;
        beats_seen   = 0;
        fetches_seen = 0;
        tiles_done   = 0;
        dones        = 0;
        first_cyc    = 0;
        last_cyc     = 0;
        exp_beat_q.delete();
        exp_addr_q.delete();
        for (int n = 0; n <= d; n++) begin
            logic [5:0] a;
            a = base + 6'(n);
            exp_addr_q.push_back(a);
            for (int r = 0; r < 8; r++) begin
                beat_t e;
                e.data = exp_row(a, r);
                e.r    = 3'(r);
                e.t    = 4'(n);
                e.last = (n == d) && (r == 7);
                exp_beat_q.push_back(e);
            end
        end
    endtask

    task automatic do_start(input logic [5:0] base);
        base_addr    = base;
        start_v[cur] = 1'b1;
        tick();
        start_v = 3'b000;
    endtask

    task automatic finish_window(input int exp_beats, input int exp_fetches);
        int t;
        t = 0;
        while (dones == 0 && t < 600) begin
            row_ready = 1'b1;
            tick();
            t++;
        end
        if (dones == 0) chk_int("done_timeout", 0, 1);
        repeat (3) tick();
        chk_int("done_once", dones, 1);
        chk_int("beat_count", beats_seen, exp_beats);
        chk_int("fetch_count", fetches_seen, exp_fetches);
        chk_int("busy_after", int'(busy), 0);
        chk_int("exp_left", exp_beat_q.size(), 0);
    endtask

    task automatic run_window(input vec_t v);
        int k_cyc;
        int t;
        prepare(v.dut, v.base);
        row_ready = (v.mode == M_TOGGLE) ? 1'b0 : 1'b1;
        do_start(v.base);
        k_cyc = cyc;
        chk_int("rd_en_after_start", int'(rd_en), 1);
        chk_int("busy_after_start", int'(busy), 1);
        chk_int("valid_early", int'(row_valid), 0);
        tick();
        chk_int("valid_k1", int'(row_valid), 0);
        tick();
        chk_int("valid_k2", int'(row_valid), 1);
        t = 0;
        while (dones == 0 && t < 600) begin
            case (v.mode)
                M_TOGGLE: row_ready = ~row_ready;
                M_RANDOM: row_ready = 1'($urandom_range(0, 1));
                default:  row_ready = 1'b1;
            endcase
            if (v.restart && t == 3) start_v[cur] = 1'b1;
            else start_v = 3'b000;
            tick();
            t++;
        end
        start_v = 3'b000;
        if (v.mode == M_ALWAYS) begin
            chk_int("first_beat_cycle", first_cyc, k_cyc + 2);
            chk_int("back_to_back", last_cyc - first_cyc, v.exp_beats - 1);
        end
        finish_window(v.exp_beats, v.exp_fetches);
    endtask

    vec_t vecs [5];

    initial begin
        int t;
        rst_n     = 1'b0;
        cur       = 0;
        start_v   = 3'b000;
        base_addr = '0;
        row_ready = 1'b0;

        vecs[0] = '{dut:1, base:6'd5,  mode:M_ALWAYS, restart:1'b0, exp_beats:16, exp_fetches:2};
        vecs[1] = '{dut:1, base:6'd10, mode:M_TOGGLE, restart:1'b0, exp_beats:16, exp_fetches:2};
        vecs[2] = '{dut:2, base:6'd63, mode:M_ALWAYS, restart:1'b0, exp_beats:24, exp_fetches:3};
        vecs[3] = '{dut:0, base:6'd20, mode:M_ALWAYS, restart:1'b1, exp_beats:8,  exp_fetches:1};
        vecs[4] = '{dut:2, base:6'd33, mode:M_RANDOM, restart:1'b0, exp_beats:24, exp_fetches:3};

        repeat (3) tick();
        for (int g = 0; g < 3; g++)
            chk("reset_state", 300'({busy_v[g], done_v[g], rden_v[g], addr_v[g], rv_v[g],
                                     rl_v[g], ridx_v[g], tidx_v[g], rdata_v[g]}), '0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_window(vecs[i]);

        // Long stall: only two tiles may be fetched until a buffer frees.
        prepare(2, 6'd40);
        row_ready = 1'b0;
        do_start(6'd40);
        t = 0;
        while (!row_valid && t < 10) begin
            tick();
            t++;
        end
        chk_int("stall_valid_seen", int'(row_valid), 1);
        repeat (40) tick();
        chk_int("stall_fetches", fetches_seen, 2);
        chk_int("stall_rd_en", int'(rd_en), 0);
        finish_window(24, 3);

        // Reset in the middle of a window, then a clean rerun.
        prepare(2, 6'd7);
        row_ready = 1'b1;
        do_start(6'd7);
        t = 0;
        while (!(row_valid && row_idx == 3'd4 && tile_idx == 4'd1) && t < 40) begin
            tick();
            t++;
        end
        chk_int("reset_point_found", int'(row_valid && row_idx == 3'd4 && tile_idx == 4'd1), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 300'({busy, done, rd_en, rd_addr, row_valid, row_last,
                                         row_idx, tile_idx, row_data}), '0);
        exp_beat_q.delete();
        exp_addr_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk_int("no_done_on_reset", dones, 0);
        run_window('{dut:2, base:6'd7, mode:M_ALWAYS, restart:1'b0, exp_beats:24, exp_fetches:3});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
